seg_display_driver: RTL and testbench
=====================================

Name: seg_display_driver

Overview:
- Output-side counterpart to the button input conditioning. It takes a calculator result as magnitude plus sign, converts it to BCD with a sequential double-dabble, and drives a 4-digit multiplexed, active-low seven-segment display.
- It sits between the calculator ALU/result register and the board's anode and cathode pins.
- Digit scanning uses a free-running refresh counter that divides the 100 MHz system clock.

Parameters:
- REFRESH_BITS, 17, refresh counter width. The digit advances every 2^(REFRESH_BITS-2) clocks, about 763 Hz per digit at 100 MHz. Set to 4 in simulation.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-high reset.
- load  input  1  single-cycle strobe that captures value and neg; honoured only when busy=0.
- value  input  14  unsigned result magnitude.
- neg  input  1  result is negative.
- busy  output  1  high while a conversion is in progress.
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  output  7  cathodes, active-low, seg[6:0]={g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FSM goes to IDLE and busy=0.
  - Refresh counter clears to 0, so an=4'b1110.
  - Display registers hold "   0": digit0 shows '0', digits 3..1 are blank. Output seg=7'b1000000.
  - Any in-flight conversion or captured operand is discarded.
- FSM states: IDLE, CONV, COMMIT. busy = (state != IDLE).
  - IDLE: when load=1 at edge N, latch value and neg, clear the BCD shift register and the iteration count, and go to CONV.
  - CONV: one double-dabble iteration per edge. First add 3 to every BCD nibble >= 5, then shift left one bit, taking the next value MSB. Iterations run on edges N+1..N+14; after the 14th, go to COMMIT.
  - COMMIT: at edge N+15, write the four digit-code registers and return to IDLE.
  - busy is high for exactly 15 cycles after the load edge. New digits are visible from edge N+15.
- load while busy=1 is ignored and not queued. load held high in IDLE starts a new conversion every 16 cycles.
- Overflow: value > 9999 with neg=0, or value > 999 with neg=1.
  - Display shows blank, 'E', 'r', 'r' on digits 3..0.
  - The thousands nibble may wrap during conversion; this is harmless because overflow overrides it.
- Negative, not overflowed: digit3 always shows '-'. Digits 2..0 show the hundreds, tens and units.
- Leading-zero blanking (with the Optional Feature compiled in), for non-error results:
  - Digit3 is blank when the thousands digit is 0 (positive results only).
  - Digit2 is blank when all higher magnitude digits are 0.
  - Digit1 follows the same rule as digit2.
  - Digit0 is never blanked.
- Segment codes ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, 'E'=0000110, 'r'=0101111, blank=1111111
- Scanner:
  - Digit index = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2]. an is one-hot low at that index.
  - seg is registered from the selected digit-code register, so it lags the digit index by one cycle.
  - an is registered the same way, keeping an and seg aligned and glitch-free.
- The counter wraps freely. Index 3→0 wraparound needs no special handling.
- COMMIT coinciding with a digit switch: the new code appears on the next registered update. No torn digit is allowed.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading-zero blanking as described in Behaviour.
- Undefined: all magnitude digits are shown with zeros. A positive result shows digit3; a negative result still puts '-' in digit3. Reset display is "0000".
- Error display is identical in both builds.

Test Plan (REFRESH_BITS=4, LEADING_ZERO_BLANK_EN defined):
- Assert and release rst, then run 64 cycles.
  - busy=0 throughout.
  - an steps 1110, 1101, 1011, 0111, each held for 4 cycles.
  - seg=1000000 on digit0 and 1111111 on the other digits.
- load value=1234 neg=0.
  - busy=1 for exactly 15 cycles.
  - Digits 3..0 then read 1111001, 0100100, 0110000, 0011001.
- load value=5 neg=1.
  - Digit3=0111111, digits 2 and 1=1111111, digit0=0010010.
- load value=10000 neg=0, then value=1000 neg=1.
  - Both give digits 3..0 = 1111111, 0000110, 0101111, 0101111.
- load value=42, then load value=77 three cycles later.
  - The second load is ignored and busy stays high for only 15 cycles.
  - Display reads blank, blank, 4, 2.
- Assert rst 7 cycles into a conversion of 9999.
  - busy falls immediately and the display shows "   0".
  - A subsequent load of 9999 gives 0010000 on all four digits after 15 cycles.

Source files
------------

// File: rtl/seg_display_driver_if.sv
// Calculator-result / display-pin bundle for seg_display_driver.
// master = result producer side; slave = the display driver.
interface seg_display_driver_if;
  logic        load;
  logic [13:0] value;
  logic        neg;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output load, value, neg,
    input  busy, an, seg, dp
  );

  modport slave (
    input  load, value, neg,
    output busy, an, seg, dp
  );
endinterface

// File: rtl/seg_display_driver.sv
// Magnitude+sign to 4-digit active-low seven-segment driver with sequential double-dabble.
// Optional leading-zero blanking is compiled in with macro LEADING_ZERO_BLANK_EN.
module seg_display_driver #(
  parameter int REFRESH_BITS = 17
) (
  input  logic                clk,
  input  logic                rst,
  seg_display_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [3:0] LAST_ITER = 4'd13;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZB_EN = 1'b1;
  localparam logic [3:0][6:0] RESET_DIGITS = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
`else
  localparam logic LZB_EN = 1'b0;
  localparam logic [3:0][6:0] RESET_DIGITS = {SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_ZERO};
`endif

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit.
  // The thousands nibble may overflow for out-of-range inputs; those are shown as Err anyway.
  function automatic logic [15:0] dabble_step(input logic [15:0] b, input logic in_bit);
    logic [15:0] a;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (a[i*4 +: 4] >= 4'd5) begin
        a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
      end else begin
        a[i*4 +: 4] = a[i*4 +: 4];
      end
    end
    return {a[14:0], in_bit};
  endfunction

  state_t                  state_r;
  logic                    busy_r;
  logic [13:0]             val_r;
  logic                    neg_r;
  logic                    ovf_r;
  logic [15:0]             bcd_r;
  logic [3:0]              iter_r;
  logic [3:0][6:0]         dig_r;
  logic [REFRESH_BITS-1:0] refresh_cnt_r;
  logic [3:0]              an_r;
  logic [6:0]              seg_r;

  logic [15:0]             next_bcd_s;
  logic [3:0][6:0]         commit_dig_s;
  logic [1:0]              idx_s;
  logic                    th_zero_s;
  logic                    h_zero_s;
  logic                    t_zero_s;

  // Next BCD value for the running conversion.
  always_comb begin
    next_bcd_s = dabble_step(bcd_r, val_r[13]);
  end

  // Digit codes to be committed from the finished BCD result.
  always_comb begin
    th_zero_s    = (bcd_r[15:12] == 4'd0);
    h_zero_s     = (bcd_r[11:8]  == 4'd0);
    t_zero_s     = (bcd_r[7:4]   == 4'd0);
    commit_dig_s = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
    if (ovf_r) begin
      commit_dig_s[3] = SEG_BLANK;
      commit_dig_s[2] = SEG_E;
      commit_dig_s[1] = SEG_R;
      commit_dig_s[0] = SEG_R;
    end else begin
      // A non-overflowed negative result always has a zero thousands digit.
      if (neg_r) begin
        commit_dig_s[3] = SEG_MINUS;
      end else if (LZB_EN && th_zero_s) begin
        commit_dig_s[3] = SEG_BLANK;
      end else begin
        commit_dig_s[3] = seg_code(bcd_r[15:12]);
      end
      if (LZB_EN && th_zero_s && h_zero_s) begin
        commit_dig_s[2] = SEG_BLANK;
      end else begin
        commit_dig_s[2] = seg_code(bcd_r[11:8]);
      end
      if (LZB_EN && th_zero_s && h_zero_s && t_zero_s) begin
        commit_dig_s[1] = SEG_BLANK;
      end else begin
        commit_dig_s[1] = seg_code(bcd_r[7:4]);
      end
      commit_dig_s[0] = seg_code(bcd_r[3:0]);
    end
  end

  // Conversion FSM: capture, 14 dabble iterations, commit to digit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      val_r   <= 14'd0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
      bcd_r   <= 16'd0;
      iter_r  <= 4'd0;
      dig_r   <= RESET_DIGITS;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.load) begin
            val_r   <= bus.value;
            neg_r   <= bus.neg;
            ovf_r   <= bus.neg ? (bus.value > 14'd999) : (bus.value > 14'd9999);
            bcd_r   <= 16'd0;
            iter_r  <= 4'd0;
            state_r <= CONV;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        CONV: begin
          bcd_r  <= next_bcd_s;
          val_r  <= {val_r[12:0], 1'b0};
          iter_r <= iter_r + 4'd1;
          if (iter_r == LAST_ITER) begin
            state_r <= COMMIT;
          end else begin
            state_r <= CONV;
          end
        end
        COMMIT: begin
          dig_r   <= commit_dig_s;
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign idx_s = refresh_cnt_r[REFRESH_BITS-1:REFRESH_BITS-2];

  // Digit scanner; an and seg are registered together so they switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_r <= {REFRESH_BITS{1'b0}};
      an_r          <= 4'b1110;
      seg_r         <= SEG_ZERO;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an_r          <= ~(4'b0001 << idx_s);
      seg_r         <= dig_r[idx_s];
    end
  end

  assign bus.busy = busy_r;
  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed self-checking bench for seg_display_driver (REFRESH_BITS=4).
// Blank-or-zero expectations follow LEADING_ZERO_BLANK_EN the same way the build does.
module tb_seg_display_driver;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_MINUS = 7'b0111111;
  localparam logic [6:0] S_E     = 7'b0000110;
  localparam logic [6:0] S_R     = 7'b0101111;
  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_2     = 7'b0100100;
  localparam logic [6:0] S_3     = 7'b0110000;
  localparam logic [6:0] S_4     = 7'b0011001;
  localparam logic [6:0] S_5     = 7'b0010010;
  localparam logic [6:0] S_9     = 7'b0010000;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] S_LZ  = S_BLANK;
`else
  localparam logic [6:0] S_LZ  = S_0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg_display_driver_if bus ();

  seg_display_driver #(.REFRESH_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Pulse load, optionally inject a second load at a given busy cycle, return busy length.
  task automatic load_and_count(input logic [13:0] v, input logic n, input int inject_at,
                                input logic [13:0] v2, output int busy_cycles);
    int cnt;
    @(negedge clk);
    bus.value = v;
    bus.neg   = n;
    bus.load  = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      if (cnt == inject_at) begin
        bus.value = v2;
        bus.load  = 1'b1;
      end else begin
        bus.load  = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.load    = 1'b0;
    busy_cycles = cnt;
  endtask

  // Scan until every anode has been seen once and compare the captured segments.
  task automatic expect_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] cap [4];
    logic [3:0] seen;
    int         n;
    seen = 4'b0000;
    n    = 0;
    for (int i = 0; i < 4; i++) cap[i] = 7'bxxxxxxx;
    while (seen != 4'b1111 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      case (bus.an)
        4'b1110: begin cap[0] = bus.seg; seen[0] = 1'b1; end
        4'b1101: begin cap[1] = bus.seg; seen[1] = 1'b1; end
        4'b1011: begin cap[2] = bus.seg; seen[2] = 1'b1; end
        4'b0111: begin cap[3] = bus.seg; seen[3] = 1'b1; end
        default: begin end
      endcase
    end
    check_eq({tag, "_scan"}, {12'd0, seen}, 16'h000f);
    check_eq({tag, "_d3"}, {9'd0, cap[3]}, {9'd0, e3});
    check_eq({tag, "_d2"}, {9'd0, cap[2]}, {9'd0, e2});
    check_eq({tag, "_d1"}, {9'd0, cap[1]}, {9'd0, e1});
    check_eq({tag, "_d0"}, {9'd0, cap[0]}, {9'd0, e0});
  endtask

  initial begin
    int         bc;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.load  = 1'b0;
    bus.value = 14'd0;
    bus.neg   = 1'b0;

    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy", {15'd0, bus.busy}, 16'd0);
    check_eq("rst_an",   {12'd0, bus.an},   16'b1110);
    check_eq("rst_seg",  {9'd0, bus.seg},   {9'd0, S_0});
    check_eq("dp_off",   {15'd0, bus.dp},   16'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle scan: each anode held 4 cycles, digit0 '0', others blank (or '0').
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      exp_an  = ~(4'b0001 << (((k - 1) >> 2) & 3));
      exp_seg = (exp_an == 4'b1110) ? S_0 : S_LZ;
      check_eq("idle_busy", {15'd0, bus.busy}, 16'd0);
      check_eq("idle_an",   {12'd0, bus.an},   {12'd0, exp_an});
      check_eq("idle_seg",  {9'd0, bus.seg},   {9'd0, exp_seg});
    end

    load_and_count(14'd1234, 1'b0, 0, 14'd0, bc);
    check_eq("busy_1234", bc[15:0], 16'd15);
    expect_display("v1234", S_1, S_2, S_3, S_4);

    load_and_count(14'd5, 1'b1, 0, 14'd0, bc);
    check_eq("busy_neg5", bc[15:0], 16'd15);
    expect_display("neg5", S_MINUS, S_LZ, S_LZ, S_5);

    load_and_count(14'd10000, 1'b0, 0, 14'd0, bc);
    check_eq("busy_10000", bc[15:0], 16'd15);
    expect_display("ovf_pos", S_BLANK, S_E, S_R, S_R);

    load_and_count(14'd1000, 1'b1, 0, 14'd0, bc);
    check_eq("busy_neg1000", bc[15:0], 16'd15);
    expect_display("ovf_neg", S_BLANK, S_E, S_R, S_R);

    load_and_count(14'd42, 1'b0, 3, 14'd77, bc);
    check_eq("busy_ignore", bc[15:0], 16'd15);
    expect_display("v42", S_LZ, S_LZ, S_4, S_2);

    // Reset mid-conversion discards the operand and restores the idle display.
    @(negedge clk);
    bus.value = 14'd9999;
    bus.neg   = 1'b0;
    bus.load  = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", {15'd0, bus.busy}, 16'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", {15'd0, bus.busy}, 16'd0);
    check_eq("mid_rst_an",   {12'd0, bus.an},   16'b1110);
    check_eq("mid_rst_seg",  {9'd0, bus.seg},   {9'd0, S_0});
    @(negedge clk);
    rst = 1'b0;
    expect_display("after_rst", S_LZ, S_LZ, S_LZ, S_0);

    load_and_count(14'd9999, 1'b0, 0, 14'd0, bc);
    check_eq("busy_9999", bc[15:0], 16'd15);
    expect_display("v9999", S_9, S_9, S_9, S_9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
